// File: rtl/fifo_rd_stream.sv
// Read-domain drain engine: pops an async FIFO with one-cycle read latency,
// buffers words in a 3-entry in-order queue and presents them on valid/ready.
module fifo_rd_stream #(
  parameter int DSIZE = 8,
  parameter int CNTW  = 16
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             rEmpty,
  input  logic [DSIZE-1:0] rData,
  output logic             rinc,
  output logic [DSIZE-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [CNTW-1:0]  rd_count
);

  localparam int DEPTH = 3;

  logic [DEPTH-1:0][DSIZE-1:0] q;
  logic [2:0]                  occ;
  logic                        inflight;
  logic [1:0]                  head, tail;
  logic                        fire;
  logic [2:0]                  committed;

  function automatic logic [1:0] ptr_nxt(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Credit covers the word still on its way out of the FIFO, so a pop is
  // only issued when a queue slot is guaranteed on arrival. m_ready is
  // deliberately excluded to keep rinc off the downstream timing path.
  assign committed = occ + {2'b00, inflight};
  assign rinc      = !rrst && !rEmpty && (committed < 3'(DEPTH));

  assign m_valid = (occ != 3'd0);
  assign m_data  = q[head];
  assign fire    = m_valid && m_ready;

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      q        <= '0;
      occ      <= 3'd0;
      inflight <= 1'b0;
      head     <= 2'd0;
      tail     <= 2'd0;
      rd_count <= '0;
    end else begin
      inflight <= rinc;
      if (inflight) begin
        q[tail] <= rData;
        tail    <= ptr_nxt(tail);
      end
      if (fire) begin
        head     <= ptr_nxt(head);
        rd_count <= rd_count + 1'b1;
      end
      occ <= occ + {2'b00, inflight} - {2'b00, fire};
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: behavioural FIFO read port feeding the DUT,
// scoreboard on the output stream, table-driven bursts plus corner sequences.
module tb_fifo_rd_stream;

  localparam int DSIZE = 8;
  localparam int CNTW  = 9;

  logic             rclk = 1'b0;
  logic             rrst;
  logic             rEmpty = 1'b1;
  logic [DSIZE-1:0] rData = '0;
  logic             rinc;
  logic [DSIZE-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
  logic [CNTW-1:0]  rd_count;

  fifo_rd_stream #(.DSIZE(DSIZE), .CNTW(CNTW)) dut (
    .rclk(rclk), .rrst(rrst), .rEmpty(rEmpty), .rData(rData), .rinc(rinc),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .rd_count(rd_count)
  );

  always #5 rclk = ~rclk;

  int checks = 0, failures = 0;
  int pops = 0, fires = 0;
  logic [DSIZE-1:0] fifo_q[$];
  logic [DSIZE-1:0] exp_q[$];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // FIFO read port: data and empty flag are both registered on rclk.
  always @(posedge rclk) begin
    if (rinc && !rEmpty) begin
      rData <= fifo_q.pop_front();
      pops++;
    end
    rEmpty <= (fifo_q.size() == 0);
  end

  // Scoreboard: values here are stable until the next rising edge.
  always @(negedge rclk) begin
    if (!rrst && m_valid && m_ready) begin
      fires++;
      if (exp_q.size() == 0) chk("unexpected_word", m_data, -1);
      else chk("stream_data", m_data, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic push(input logic [DSIZE-1:0] d);
    fifo_q.push_back(d);
    exp_q.push_back(d);
  endtask

  task automatic start_reset();
    rrst = 1'b1;
    fifo_q.delete();
    exp_q.delete();
  endtask

  task automatic drain(input string nm, input int bound);
    int t;
    for (t = 0; t < bound && exp_q.size() > 0; t++) tick();
    chk(nm, exp_q.size(), 0);
  endtask

  typedef struct {
    int n;          // words pushed
    int stall_at;   // fires before m_ready drops
    int stall_len;  // cycles m_ready stays low
    bit rnd;        // random m_ready every cycle
    int exp_cnt;    // rd_count after the row, mod 2^CNTW
  } vec_t;

  vec_t vecs[5];

  initial begin
    int n, held, base;
    vecs[0] = '{n: 1,   stall_at: 0,   stall_len: 0, rnd: 1'b0, exp_cnt: 1};
    vecs[1] = '{n: 5,   stall_at: 2,   stall_len: 3, rnd: 1'b0, exp_cnt: 6};
    vecs[2] = '{n: 300, stall_at: 100, stall_len: 4, rnd: 1'b0, exp_cnt: 306};
    vecs[3] = '{n: 250, stall_at: 0,   stall_len: 0, rnd: 1'b1, exp_cnt: 44};
    vecs[4] = '{n: 3,   stall_at: 1,   stall_len: 2, rnd: 1'b0, exp_cnt: 47};

    // Reset state with a non-empty FIFO, then a single word.
    m_ready = 1'b1;
    start_reset();
    push(8'hA5);
    tick(); tick();
    chk("rst_rinc", rinc, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_rd_count", rd_count, 0);
    pops = 0;
    rrst = 1'b0;
    #1;
    chk("rinc_after_release", rinc, 1);
    tick();
    chk("single_valid_e0", m_valid, 0);
    chk("single_rinc_e0", rinc, 0);
    tick();
    chk("single_valid_e1", m_valid, 1);
    chk("single_data_e1", m_data, 8'hA5);
    tick();
    chk("single_rd_count", rd_count, 1);
    chk("single_valid_after", m_valid, 0);
    chk("single_pops", pops, 1);

    // Full-rate streaming of 0x00..0xFF.
    start_reset();
    for (int i = 0; i < 256; i++) push(8'(i));
    tick(); tick();
    rrst = 1'b0;
    n = 0;
    while (exp_q.size() > 0 && n < 400) begin
      tick();
      n++;
    end
    chk("stream_cycles", n, 258);
    chk("stream_rd_count", rd_count, 256);
    chk("stream_rinc_empty", rinc, 0);
    chk("stream_valid_empty", m_valid, 0);

    // Backpressure mid-stream.
    start_reset();
    for (int i = 0; i < 40; i++) push(8'(i * 3 + 1));
    tick(); tick();
    rrst = 1'b0;
    base = fires;
    for (int t = 0; t < 50 && fires - base < 5; t++) tick();
    m_ready = 1'b0;
    held = m_data;
    for (int t = 0; t < 10; t++) begin
      tick();
      chk("bp_data_hold", m_data, held);
    end
    chk("bp_occ_full", dut.occ, 3);
    chk("bp_rinc_low", rinc, 0);
    chk("bp_valid_held", m_valid, 1);
    m_ready = 1'b1;
    drain("bp_drain", 100);
    chk("bp_rd_count", rd_count, 40);

    // Empty flag rises right after the last pop while stalled.
    start_reset();
    m_ready = 1'b0;
    push(8'h3C);
    push(8'hC3);
    tick(); tick();
    rrst = 1'b0;
    pops = 0;
    repeat (6) tick();
    chk("race_pops", pops, 2);
    chk("race_rinc", rinc, 0);
    chk("race_occ", dut.occ, 2);
    m_ready = 1'b1;
    drain("race_drain", 20);
    chk("race_rd_count", rd_count, 2);

    // Reset with occ=2 and a word in flight.
    start_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 10; i++) push(8'(8'h50 + i));
    tick(); tick();
    rrst = 1'b0;
    base = fires;
    for (int t = 0; t < 30 && fires - base < 3; t++) tick();
    m_ready = 1'b0;
    for (int t = 0; t < 10 && !(dut.occ == 3'd2 && dut.inflight); t++) tick();
    chk("mid_occ_pre", dut.occ, 2);
    chk("mid_inflight_pre", dut.inflight, 1);
    start_reset();
    #1;
    chk("mid_valid_async", m_valid, 0);
    chk("mid_rd_count_async", rd_count, 0);
    tick(); tick();
    for (int i = 0; i < 3; i++) push(8'(8'hC0 + i));
    rrst = 1'b0;
    m_ready = 1'b1;
    drain("mid_drain", 20);
    repeat (3) tick();
    chk("mid_rd_count", rd_count, 3);
    chk("mid_valid_idle", m_valid, 0);

    // Table-driven bursts, cumulative count crosses the 2^CNTW wrap.
    start_reset();
    tick(); tick();
    rrst = 1'b0;
    foreach (vecs[r]) begin
      int st;
      st = 0;
      for (int i = 0; i < vecs[r].n; i++) push(8'($urandom));
      base = fires;
      for (int t = 0; t < 4 * vecs[r].n + 50 && exp_q.size() > 0; t++) begin
        if (vecs[r].rnd) m_ready = 1'($urandom_range(0, 1));
        else if (fires - base >= vecs[r].stall_at && st < vecs[r].stall_len) begin
          m_ready = 1'b0;
          st++;
        end else m_ready = 1'b1;
        tick();
      end
      m_ready = 1'b1;
      chk("row_drain", exp_q.size(), 0);
      chk("row_rd_count", rd_count, vecs[r].exp_cnt);
      tick(); tick();
      chk("row_idle_valid", m_valid, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
